mor1kx_sync_fifo_sclk: RTL and testbench



---
 rtl/mor1kx_simple_dpram_sclk.sv | 56 +++++
 rtl/mor1kx_sync_fifo_sclk.sv | 96 +++++++++
 tb/tb_mor1kx_sync_fifo_sclk.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mor1kx_simple_dpram_sclk.sv
// Single-clock simple dual-port RAM: one write port, one registered read port.
// With ENABLE_BYPASS set, a same-cycle read of the address being written
// returns the incoming write data instead of the stale array contents.
module mor1kx_simple_dpram_sclk #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ENABLE_BYPASS = 1,
  parameter int CLEAR_ON_INIT = 0
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Power-on clearing would need initial contents, which this RAM cannot provide
  generate
    if (CLEAR_ON_INIT != 0) begin : g_clear_unsupported
      $error("mor1kx_simple_dpram_sclk: CLEAR_ON_INIT is not supported");
    end
  endgenerate

  // Read data only changes when a read is requested; bypass covers read-during-write
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      if ((ENABLE_BYPASS != 0) && we && (waddr == raddr)) begin
        rdata_d = din;
      end else begin
        rdata_d = mem[raddr];
      end
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= din;
    end
  end

  // Registered read port, intentionally not reset
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign dout = rdata_q;

endmodule

// File: rtl/mor1kx_sync_fifo_sclk.sv
// Show-ahead FIFO built on a simple dual-port RAM. The RAM's registered read
// output is the FIFO head; head_valid tracks whether that register holds a
// live word, so total occupancy is RAM words plus the head.
module mor1kx_sync_fifo_sclk #(
  parameter int DEPTH_WIDTH = 4,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [DEPTH_WIDTH:0]  count,
  output logic                  full,
  output logic                  empty
);

  localparam logic [DEPTH_WIDTH:0] RAM_CAP = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH:0] PTR_ONE = {{DEPTH_WIDTH{1'b0}}, 1'b1};

  logic [DEPTH_WIDTH:0] wr_ptr_d, wr_ptr_q;
  logic [DEPTH_WIDTH:0] rd_ptr_d, rd_ptr_q;
  logic                 head_valid_d, head_valid_q;
  logic [DEPTH_WIDTH:0] ram_cnt;
  logic                 wr_fire;
  logic                 rd_fire;
  logic                 ram_re;

  // Occupancy, handshakes and the RAM read request
  always_comb begin
    ram_cnt  = wr_ptr_q - rd_ptr_q;
    full     = (ram_cnt == RAM_CAP);
    wr_ready = !full && rst_n;
    wr_fire  = wr_valid && wr_ready && !flush;
    rd_fire  = head_valid_q && rd_ready;
    ram_re   = ((ram_cnt != '0) || wr_fire) && (!head_valid_q || rd_fire) && !flush;
    count    = ram_cnt + {{DEPTH_WIDTH{1'b0}}, head_valid_q};
    empty    = (count == '0);
    rd_valid = head_valid_q;
  end

  // Next pointer and head state; flush overrides every other update
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    head_valid_d = head_valid_q;
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      head_valid_d = 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (ram_re) begin
        rd_ptr_d     = rd_ptr_q + PTR_ONE;
        head_valid_d = 1'b1;
      end else if (rd_fire) begin
        head_valid_d = 1'b0;
      end
    end
  end

  // Pointer and head-flag registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      head_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      head_valid_q <= head_valid_d;
    end
  end

  mor1kx_simple_dpram_sclk #(
    .ADDR_WIDTH    (DEPTH_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .ENABLE_BYPASS (1),
    .CLEAR_ON_INIT (0)
  ) u_ram (
    .clk   (clk),
    .raddr (rd_ptr_q[DEPTH_WIDTH-1:0]),
    .re    (ram_re),
    .waddr (wr_ptr_q[DEPTH_WIDTH-1:0]),
    .we    (wr_fire),
    .din   (din),
    .dout  (dout)
  );

endmodule

// File: tb/tb_mor1kx_sync_fifo_sclk.sv
// Bench for the show-ahead FIFO: a queue model of total contents drives a
// per-cycle compare, and directed sections pin expected values by hand.
module tb_mor1kx_sync_fifo_sclk;

  localparam int DW  = 4;
  localparam int DAW = 32;
  localparam int CAP = (1 << DW) + 1;

  logic           clk;
  logic           rst_n;
  logic           flush;
  logic           wr_valid;
  logic           wr_ready;
  logic [DAW-1:0] din;
  logic           rd_valid;
  logic           rd_ready;
  logic [DAW-1:0] dout;
  logic [DW:0]    count;
  logic           full;
  logic           empty;

  int assertCount  = 0;
  int failureCount = 0;

  logic [DAW-1:0] modelQ[$];

  mor1kx_sync_fifo_sclk #(
    .DEPTH_WIDTH (DW),
    .DATA_WIDTH  (DAW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .din      (din),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .dout     (dout),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failureCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let the rising edge consume them, return just after the falling edge
  task automatic applyStimulus(input logic wv, input logic [DAW-1:0] d, input logic rr, input logic fl);
    wr_valid = wv;
    din      = d;
    rd_ready = rr;
    flush    = fl;
    @(negedge clk);
    #1;
  endtask

  // Model: total FIFO contents as a queue of at most 2^DW+1 words
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modelQ.delete();
    end else if (flush) begin
      modelQ.delete();
    end else begin
      automatic bit accept = wr_valid && (modelQ.size() < CAP);
      automatic bit take   = rd_ready && (modelQ.size() > 0);
      if (take) void'(modelQ.pop_front());
      if (accept) modelQ.push_back(din);
    end
  end

  // Compare DUT outputs with the model on every falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_wr_ready", wr_ready, 0);
      checkOutput("rst_rd_valid", rd_valid, 0);
      checkOutput("rst_count", count, 0);
    end else begin
      automatic int n = modelQ.size();
      checkOutput("cyc_rd_valid", rd_valid, (n > 0));
      checkOutput("cyc_count", count, n);
      checkOutput("cyc_empty", empty, (n == 0));
      checkOutput("cyc_full", full, (n == CAP));
      checkOutput("cyc_wr_ready", wr_ready, (n < CAP));
      if (n > 0) checkOutput("cyc_dout", dout, modelQ[0]);
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_hold_wr_ready", wr_ready, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_rd_valid", rd_valid, 0);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_empty", empty, 1);
    checkOutput("reset_full", full, 0);
    checkOutput("reset_wr_ready", wr_ready, 1);

    // Single write, held head, then consume
    applyStimulus(1, 32'hA5A5A5A5, 0, 0);
    checkOutput("single_rd_valid", rd_valid, 1);
    checkOutput("single_dout", dout, 32'hA5A5A5A5);
    checkOutput("single_count", count, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 32'h0, 0, 0);
      checkOutput("single_hold_dout", dout, 32'hA5A5A5A5);
    end
    applyStimulus(0, 32'h0, 1, 0);
    checkOutput("single_empty", empty, 1);

    // Fill to capacity with reads stalled, refuse an extra word, then drain in order
    for (int i = 0; i <= 16; i++) begin
      checkOutput("fill_wr_ready", wr_ready, 1);
      applyStimulus(1, DAW'(i), 0, 0);
    end
    checkOutput("fill_count", count, 17);
    checkOutput("fill_full", full, 1);
    checkOutput("fill_wr_ready_low", wr_ready, 0);
    applyStimulus(1, 32'h99, 1, 0);
    checkOutput("full_refuse_count", count, 16);
    checkOutput("full_refuse_dout", dout, 1);
    for (int i = 1; i <= 16; i++) begin
      checkOutput("drain_dout", dout, DAW'(i));
      applyStimulus(0, 32'h0, 1, 0);
    end
    checkOutput("drain_empty", empty, 1);

    // Streaming: one word in and one out every cycle
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1, 32'h1000 + DAW'(i), 1, 0);
      checkOutput("stream_rd_valid", rd_valid, 1);
      checkOutput("stream_count_le1", (count <= 1), 1);
      checkOutput("stream_dout", dout, 32'h1000 + DAW'(i));
    end
    applyStimulus(0, 32'h0, 1, 0);
    checkOutput("stream_empty", empty, 1);

    // Flush with a simultaneous write
    for (int i = 0; i < 9; i++) applyStimulus(1, 32'h200 + DAW'(i), 0, 0);
    checkOutput("preflush_count", count, 9);
    applyStimulus(1, 32'h0000DEAD, 0, 1);
    checkOutput("flush_count", count, 0);
    checkOutput("flush_rd_valid", rd_valid, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 32'h300 + DAW'(i), 1, 0);
      checkOutput("flush_no_dead", (rd_valid && dout == 32'h0000DEAD), 0);
    end
    applyStimulus(0, 32'h0, 1, 0);

    // Random traffic, two phases biased toward filling then draining
    for (int i = 0; i < 10000; i++) begin
      automatic bit fillBias = ((i / 500) % 2) == 0;
      automatic bit wv = fillBias ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
      automatic bit rr = fillBias ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      applyStimulus(wv, $urandom, rr, ($urandom_range(0, 999) == 0));
    end
    applyStimulus(0, 32'h0, 0, 1);
    checkOutput("rand_flush_empty", empty, 1);

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 5; i++) applyStimulus(1, 32'h400 + DAW'(i), 0, 0);
    checkOutput("prereset_count", count, 5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rd_valid", rd_valid, 0);
    checkOutput("async_count", count, 0);
    checkOutput("async_wr_ready", wr_ready, 0);
    wr_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("postreset_empty", empty, 1);
    applyStimulus(1, 32'h77, 0, 0);
    checkOutput("postreset_dout", dout, 32'h77);
    checkOutput("postreset_count", count, 1);
    applyStimulus(0, 32'h0, 1, 0);
    checkOutput("postreset_drained", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failureCount);
    $finish;
  end

endmodule
